dcache_ctrl: RTL and testbench
==============================

DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 SHALL have parameter ADDR_SIZE, default 32, byte-address width.
REQ-002 SHALL have parameter DATA_SIZE, default 32, word width.
REQ-003 SHALL have parameter LINES, default 16, number of one-word lines; power of two, minimum 2.
REQ-004 SHALL have port clk  in  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  in  1  asynchronous, active-low reset (asserted at 0).
REQ-006 SHALL have port req  in  1  core access valid.
REQ-007 SHALL have port addr  in  ADDR_SIZE  core byte address; bits [1:0] ignored.
REQ-008 SHALL have port write_enable  in  1  1 = store, 0 = load.
REQ-009 SHALL have port write_data  in  DATA_SIZE  store data.
REQ-010 SHALL have port read_data  out  DATA_SIZE  load data, valid when ready=1 and write_enable=0.
REQ-011 SHALL have port hit  out  1  combinational lookup hit for the current addr.
REQ-012 SHALL have port ready  out  1  access complete this cycle.
REQ-013 SHALL have port mem_req  out  1  backing-memory request.
REQ-014 SHALL have port mem_we  out  1  backing-memory write.
REQ-015 SHALL have port mem_addr  out  ADDR_SIZE  backing-memory address, word-aligned.
REQ-016 SHALL have port mem_wdata  out  DATA_SIZE  backing-memory write data.
REQ-017 SHALL have port mem_rdata  in  DATA_SIZE  backing-memory read data, valid with mem_ack.
REQ-018 SHALL have port mem_ack  in  1  backing-memory completion, one-cycle pulse.

Function
REQ-019 SHALL be direct-mapped, write-through, no-write-allocate; index = addr[2 +: log2(LINES)], tag = remaining upper bits.
REQ-020 SHALL assert hit when req=1, the indexed line is valid, and its tag matches.
REQ-021 SHALL use FSM states IDLE, FILL, WRITE.
REQ-022 SHALL, in IDLE on a load hit, assert ready and drive read_data from the line in the same cycle (zero-wait), then remain in IDLE.
REQ-023 SHALL, in IDLE on a load miss, go to FILL; in FILL, hold mem_req=1, mem_we=0, and mem_addr={addr[ADDR_SIZE-1:2],2'b00} until mem_ack.
REQ-024 SHALL, on mem_ack in FILL, write mem_rdata and the tag into the line, set valid, assert ready with read_data=mem_rdata in that cycle, and return to IDLE.
REQ-025 SHALL, in IDLE on any store, go to WRITE; in WRITE, hold mem_req=1, mem_we=1, and mem_wdata=write_data until mem_ack, then assert ready and return to IDLE.
REQ-026 SHALL, on a store that hits, update the line data on the mem_ack cycle; a store miss SHALL leave the line unchanged.
REQ-027 SHALL expect the core to hold req, addr, write_enable, and write_data stable until ready; mem_ack is honoured no earlier than the cycle after mem_req first rises.
REQ-028 SHALL ignore mem_ack in IDLE; ready SHALL be 0 when req=0.
REQ-029 SHALL drive mem_req low for at least one cycle between consecutive memory transactions.

Reset
REQ-030 SHALL, on rst=0, immediately clear all valid bits, enter IDLE, and drive ready=0, hit=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, read_data=0.
REQ-031 SHALL abort any FILL or WRITE in progress on reset, without a line update and without ready.

Configuration
REQ-032 SHALL, when DCACHE_STATS_EN is defined, add outputs hit_count and miss_count (out, 32 bits each, reset to 0, wrapping), incremented once per completed load hit and once per load miss respectively.
REQ-033 SHALL, when DCACHE_STATS_EN is undefined, have neither port nor counter logic; all other behaviour is identical.

Verification
REQ-034 SHALL cover: reset, load 0x100 with mem_rdata=0xDEADBEEF and ack after 3 cycles -> ready on the ack cycle with read_data=0xDEADBEEF; repeat load -> hit=1 and ready in the same cycle.
REQ-035 SHALL cover: store 0x100 := 0x25 after fill -> mem_we=1, mem_wdata=0x25, ready on ack; next load 0x100 hits and returns 0x25.
REQ-036 SHALL cover: LINES=16, load 0x100 then 0x140 (same index) -> second is a miss and replaces the line; load 0x100 again -> miss.
REQ-037 SHALL cover: store 0x200 to an invalid line -> memory written, line unchanged; next load 0x200 -> miss.
REQ-038 SHALL cover: rst=0 during FILL -> mem_req drops immediately, no ready; after release, load of the same address -> miss.
REQ-039 SHALL cover: with DCACHE_STATS_EN, sequence miss, hit, hit -> hit_count=2, miss_count=1.

Source files
------------

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller with one-word lines.
// Optional hit/miss statistics counters are enabled by defining DCACHE_STATS_EN.
module dcache_ctrl #(
    parameter int ADDR_SIZE = 32,
    parameter int DATA_SIZE = 32,
    parameter int LINES     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req,
    input  logic [ADDR_SIZE-1:0] addr,
    input  logic                 write_enable,
    input  logic [DATA_SIZE-1:0] write_data,
    output logic [DATA_SIZE-1:0] read_data,
    output logic                 hit,
    output logic                 ready,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic [DATA_SIZE-1:0] mem_wdata,
    input  logic [DATA_SIZE-1:0] mem_rdata,
    input  logic                 mem_ack
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]          hit_count,
    output logic [31:0]          miss_count
`endif
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_SIZE - 2 - IDX_W;

    typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

    state_t               state_q, state_d;
    logic                 started_q, started_d;
    logic [LINES-1:0]     valid_q;
    logic [TAG_W-1:0]     tag_q  [LINES];
    logic [DATA_SIZE-1:0] data_q [LINES];

    logic [IDX_W-1:0]     idx;
    logic [TAG_W-1:0]     tag;
    logic                 ack_v;
    logic                 fill_we;
    logic                 store_we;
    logic                 unused_lsbs;

    assign idx         = addr[2 +: IDX_W];
    assign tag         = addr[ADDR_SIZE-1 -: TAG_W];
    assign hit         = req && valid_q[idx] && (tag_q[idx] == tag);
    assign unused_lsbs = ^addr[1:0];
    // An ack in the very first request cycle is not a valid completion.
    assign ack_v       = mem_ack && started_q;

    always_comb begin
        state_d   = state_q;
        started_d = 1'b0;
        ready     = 1'b0;
        read_data = '0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        fill_we   = 1'b0;
        store_we  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (write_enable) begin
                        state_d = WRITE;
                    end else if (hit) begin
                        ready     = 1'b1;
                        read_data = data_q[idx];
                    end else begin
                        state_d = FILL;
                    end
                end
            end
            FILL: begin
                mem_req   = 1'b1;
                mem_addr  = {addr[ADDR_SIZE-1:2], 2'b00};
                started_d = 1'b1;
                if (ack_v) begin
                    fill_we   = 1'b1;
                    ready     = req;
                    read_data = mem_rdata;
                    started_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            WRITE: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {addr[ADDR_SIZE-1:2], 2'b00};
                mem_wdata = write_data;
                started_d = 1'b1;
                if (ack_v) begin
                    store_we  = hit;
                    ready     = req;
                    started_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            started_q <= 1'b0;
            valid_q   <= '0;
        end else begin
            state_q   <= state_d;
            started_q <= started_d;
            if (fill_we) valid_q[idx] <= 1'b1;
        end
    end

    // Tag/data arrays need no reset: valid bits gate every use.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            tag_q[idx]  <= tag;
            data_q[idx] <= mem_rdata;
        end else if (store_we) begin
            data_q[idx] <= write_data;
        end
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (state_q == IDLE && req && !write_enable) begin
            if (hit) hit_cnt_q  <= hit_cnt_q + 32'd1;
            else     miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: directed vector table, reset corner cases,
// and random accesses checked against a line-map / flat-memory reference model.
module tb_dcache_ctrl;

    localparam int LINES = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [31:0] addr;
    logic        write_enable;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        hit;
    logic        ready;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
`ifdef DCACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    always #5 clk = ~clk;

    dcache_ctrl #(.ADDR_SIZE(32), .DATA_SIZE(32), .LINES(LINES)) dut (
        .clk(clk), .rst(rst), .req(req), .addr(addr),
        .write_enable(write_enable), .write_data(write_data),
        .read_data(read_data), .hit(hit), .ready(ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
`ifdef DCACHE_STATS_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Backing store seen by the DUT, and the reference model's own view of memory.
    logic [31:0] bmem [int unsigned];
    logic [31:0] refm [int unsigned];
    bit          mvalid [LINES];
    int unsigned mline  [LINES];

    typedef struct {
        logic        we;
        logic [31:0] a;
        logic [31:0] d;
        int          lat;
        logic        eh;
        logic [31:0] ed;
        int          ec;
    } vec_t;
    vec_t tbl [9];

    function automatic logic [31:0] seed_val(input int unsigned wa);
        return (wa * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    function logic [31:0] bget(input int unsigned wa);
        return bmem.exists(wa) ? bmem[wa] : seed_val(wa);
    endfunction

    function logic [31:0] rget(input int unsigned wa);
        return refm.exists(wa) ? refm[wa] : seed_val(wa);
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < LINES; i++) mvalid[i] = 1'b0;
    endtask

    // Reference: a line holds whatever word was last filled into its index; data always comes from memory.
    task automatic ref_access(input logic w, input logic [31:0] a, input logic [31:0] d, input int lat,
                              output logic eh, output logic [31:0] ed, output int ec);
        int unsigned wa  = a >> 2;
        int unsigned idx = wa % LINES;
        eh = mvalid[idx] && (mline[idx] == wa);
        ed = '0;
        if (w) begin
            refm[wa] = d;
            ec = lat + 2;
        end else begin
            ed = rget(wa);
            ec = eh ? 1 : lat + 2;
            if (!eh) begin
                mvalid[idx] = 1'b1;
                mline[idx]  = wa;
            end
        end
    endtask

    // Drives one core access and plays the backing memory (ack lat cycles after mem_req rises).
    task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d, input int lat,
                          output logic h0, output logic [31:0] rdv, output int cyc);
        int   reqcyc = 0;
        logic done   = 1'b0;
        req = 1'b1; write_enable = w; addr = a; write_data = d;
        h0 = 1'b0; rdv = '0; cyc = 0;
        while (!done && cyc < 50) begin
            @(negedge clk);
            reqcyc = mem_req ? reqcyc + 1 : 0;
            if (mem_req && reqcyc == lat + 1) begin
                mem_ack = 1'b1;
                if (mem_we) bmem[mem_addr >> 2] = mem_wdata;
                else        mem_rdata = bget(mem_addr >> 2);
                chk("mem_addr", mem_addr, {a[31:2], 2'b00});
                chk("mem_we", {31'b0, mem_we}, {31'b0, w});
                if (w) chk("mem_wdata", mem_wdata, d);
            end
            #1;
            if (cyc == 0) h0 = hit;
            if (ready) begin
                done = 1'b1;
                rdv  = read_data;
            end
            @(posedge clk);
            #1;
            mem_ack = 1'b0;
            cyc++;
        end
        req = 1'b0;
        chk("ready_within_bound", {31'b0, done}, 32'd1);
    endtask

    task automatic check_access(input string nm, input logic w, input logic [31:0] a, input logic [31:0] d,
                                input int lat, input logic eh, input logic [31:0] ed, input int ec);
        logic        h0;
        logic [31:0] rdv;
        int          cyc;
        access(w, a, d, lat, h0, rdv, cyc);
        chk({nm, "_hit"}, {31'b0, h0}, {31'b0, eh});
        chk({nm, "_cycles"}, cyc, ec);
        if (!w) chk({nm, "_rdata"}, rdv, ed);
    endtask

    // Consecutive memory transactions must be separated by a cycle with mem_req low.
    logic prev_done = 1'b0;
    always begin
        @(negedge clk);
        #2;
        if (rst && prev_done) chk("mem_req_gap", {31'b0, mem_req}, 32'd0);
        prev_done = rst && mem_req && mem_ack;
    end

    initial begin
        logic        eh;
        logic [31:0] ed;
        int          ec;
        logic        w;
        logic [31:0] a, d;
        int          lat;

        tbl[0] = '{1'b0, 32'h100, 32'h0,    3, 1'b0, 32'hDEADBEEF, 5};
        tbl[1] = '{1'b0, 32'h100, 32'h0,    1, 1'b1, 32'hDEADBEEF, 1};
        tbl[2] = '{1'b1, 32'h100, 32'h25,   2, 1'b1, 32'h0,        4};
        tbl[3] = '{1'b0, 32'h101, 32'h0,    1, 1'b1, 32'h25,       1};
        tbl[4] = '{1'b0, 32'h140, 32'h0,    1, 1'b0, 32'h14014014, 3};
        tbl[5] = '{1'b0, 32'h100, 32'h0,    1, 1'b0, 32'h25,       3};
        tbl[6] = '{1'b1, 32'h200, 32'hCAFE, 2, 1'b0, 32'h0,        4};
        tbl[7] = '{1'b0, 32'h200, 32'h0,    1, 1'b0, 32'hCAFE,     3};
        tbl[8] = '{1'b0, 32'h203, 32'h0,    1, 1'b1, 32'hCAFE,     1};

        bmem[32'h100 >> 2] = 32'hDEADBEEF; refm[32'h100 >> 2] = 32'hDEADBEEF;
        bmem[32'h140 >> 2] = 32'h14014014; refm[32'h140 >> 2] = 32'h14014014;
        model_clear();

        // Reset with a live request: all outputs quiet.
        rst = 1'b0; req = 1'b1; addr = 32'h100; write_enable = 1'b0; write_data = 32'h0;
        mem_rdata = 32'h0; mem_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", {31'b0, ready}, 32'd0);
        chk("rst_hit", {31'b0, hit}, 32'd0);
        chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
        chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_read_data", read_data, 32'd0);
        req = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 9; i++) begin
            ref_access(tbl[i].we, tbl[i].a, tbl[i].d, tbl[i].lat, eh, ed, ec);
            check_access($sformatf("vec%0d", i), tbl[i].we, tbl[i].a, tbl[i].d, tbl[i].lat,
                         tbl[i].eh, tbl[i].ed, tbl[i].ec);
        end

        // Reset asserted while a fill is outstanding.
        req = 1'b1; write_enable = 1'b0; addr = 32'h300;
        @(negedge clk);
        @(negedge clk);
        chk("fill_mem_req", {31'b0, mem_req}, 32'd1);
        #1;
        rst = 1'b0;
        #1;
        chk("abort_mem_req", {31'b0, mem_req}, 32'd0);
        chk("abort_ready", {31'b0, ready}, 32'd0);
        @(negedge clk);
        chk("abort_ready_late", {31'b0, ready}, 32'd0);
        @(posedge clk);
        #1;
        req = 1'b0;
        rst = 1'b1;
        model_clear();
        @(posedge clk);
        #1;

        check_access("post_rst_miss", 1'b0, 32'h300, 32'h0, 2, 1'b0, bget(32'h300 >> 2), 4);
        check_access("post_rst_hit1", 1'b0, 32'h300, 32'h0, 1, 1'b1, bget(32'h300 >> 2), 1);
        check_access("post_rst_hit2", 1'b0, 32'h300, 32'h0, 1, 1'b1, bget(32'h300 >> 2), 1);
`ifdef DCACHE_STATS_EN
        chk("hit_count", hit_count, 32'd2);
        chk("miss_count", miss_count, 32'd1);
`endif
        mvalid[(32'h300 >> 2) % LINES] = 1'b1;
        mline[(32'h300 >> 2) % LINES]  = 32'h300 >> 2;
        check_access("post_rst_old_line", 1'b0, 32'h100, 32'h0, 1, 1'b0, 32'h25, 3);
        mvalid[(32'h100 >> 2) % LINES] = 1'b1;
        mline[(32'h100 >> 2) % LINES]  = 32'h100 >> 2;

        for (int i = 0; i < 300; i++) begin
            w   = ($urandom_range(0, 9) < 3);
            a   = (32'($urandom_range(0, 47)) << 2) | 32'($urandom_range(0, 3));
            d   = $urandom;
            lat = $urandom_range(1, 4);
            ref_access(w, a, d, lat, eh, ed, ec);
            check_access($sformatf("rnd%0d", i), w, a, d, lat, eh, ed, ec);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
